// File: rtl/snitch_shared_acc_mux.sv
// Shared accelerator port mux for a group of Snitch cores.
// Round-robin request merge with credits; hart-ID based response demux.
package snitch_shared_acc_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  id;
        logic [31:0] data_op;
        logic [63:0] data_arga;
        logic [63:0] data_argb;
        logic [63:0] data_argc;
    } acc_req_t;

    typedef struct packed {
        logic [5:0]  hart_id;
        logic [31:0] addr;
        logic [4:0]  id;
        logic [31:0] data_op;
        logic [63:0] data_arga;
        logic [63:0] data_argb;
        logic [63:0] data_argc;
    } sh_acc_req_t;

    typedef struct packed {
        logic [4:0]  id;
        logic        error;
        logic [63:0] data;
    } acc_resp_t;

    typedef struct packed {
        logic [5:0]  hart_id;
        logic [4:0]  id;
        logic        error;
        logic [63:0] data;
    } sh_acc_resp_t;

endpackage

module snitch_shared_acc_mux
    import snitch_shared_acc_pkg::*;
#(
    parameter int unsigned NrCores        = 4,
    parameter int unsigned HartIdBase     = 0,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  acc_req_t           core_req_i [NrCores],
    input  logic [NrCores-1:0] core_req_valid_i,
    output logic [NrCores-1:0] core_req_ready_o,
    output acc_resp_t          core_resp_o [NrCores],
    output logic [NrCores-1:0] core_resp_valid_o,
    input  logic [NrCores-1:0] core_resp_ready_i,
    output sh_acc_req_t        acc_req_o,
    output logic               acc_req_valid_o,
    input  logic               acc_req_ready_i,
    input  sh_acc_resp_t       acc_resp_i,
    input  logic               acc_resp_valid_i,
    output logic               acc_resp_ready_o,
    output logic               unexpected_resp_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned IdxW = (NrCores > 1) ? $clog2(NrCores) : 1;

    logic [CntW-1:0]    cnt_q [NrCores];
    logic [CntW-1:0]    cnt_d [NrCores];
    logic [IdxW-1:0]    rr_q, rr_d;
    logic               out_valid_q, out_valid_d;
    sh_acc_req_t        out_q, out_d;
    logic               unexp_q, unexp_d;

    logic [NrCores-1:0] elig;
    logic               found;
    logic [IdxW-1:0]    gnt_idx;
    logic [IdxW:0]      cand;
    logic [IdxW:0]      nxt;
    logic               slot_free;
    logic               accept;

    logic [5:0]         resp_off;
    logic               matched;
    logic [IdxW-1:0]    resp_idx;
    logic               resp_hs;

    // Eligibility: valid request and a free credit held at cycle start
    always_comb begin
        for (int i = 0; i < NrCores; i++) begin
            elig[i] = core_req_valid_i[i]
                   && (cnt_q[i] < CntW'(MaxOutstanding));
        end
    end

    // Round-robin search starting at rr_q
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NrCores; k++) begin
            cand = {1'b0, rr_q} + (IdxW+1)'(k);
            if (cand >= (IdxW+1)'(NrCores)) begin
                cand = cand - (IdxW+1)'(NrCores);
            end
            if (!found && elig[cand[IdxW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[IdxW-1:0];
            end
        end
    end

    assign slot_free = !out_valid_q || acc_req_ready_i;
    assign accept    = found && slot_free;

    // Ready only to the granted core, and only if the register can take it
    always_comb begin
        core_req_ready_o = '0;
        if (found && slot_free) begin
            core_req_ready_o[gnt_idx] = 1'b1;
        end
    end

    // Next request register contents and round-robin pointer
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        rr_d        = rr_q;
        nxt         = {1'b0, gnt_idx} + (IdxW+1)'(1);
        if (accept) begin
            out_d.hart_id   = 6'(HartIdBase) + 6'(gnt_idx);
            out_d.addr      = core_req_i[gnt_idx].addr;
            out_d.id        = core_req_i[gnt_idx].id;
            out_d.data_op   = core_req_i[gnt_idx].data_op;
            out_d.data_arga = core_req_i[gnt_idx].data_arga;
            out_d.data_argb = core_req_i[gnt_idx].data_argb;
            out_d.data_argc = core_req_i[gnt_idx].data_argc;
            out_valid_d     = 1'b1;
            if (nxt >= (IdxW+1)'(NrCores)) begin
                rr_d = '0;
            end else begin
                rr_d = nxt[IdxW-1:0];
            end
        end else if (acc_req_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    assign acc_req_o       = out_q;
    assign acc_req_valid_o = out_valid_q;

    // Response demux by hart ID offset (wraps modulo 64)
    assign resp_off = acc_resp_i.hart_id - 6'(HartIdBase);
    assign matched  = resp_off < 6'(NrCores);
    assign resp_idx = resp_off[IdxW-1:0];

    // Route valid/ready to the addressed core; drop unmatched responses
    always_comb begin
        core_resp_valid_o = '0;
        acc_resp_ready_o  = 1'b1;
        if (matched) begin
            core_resp_valid_o[resp_idx] = acc_resp_valid_i;
            acc_resp_ready_o = core_resp_ready_i[resp_idx];
        end
    end

    // Payload is broadcast; only the valid bit selects the core
    always_comb begin
        for (int i = 0; i < NrCores; i++) begin
            core_resp_o[i].id    = acc_resp_i.id;
            core_resp_o[i].error = acc_resp_i.error;
            core_resp_o[i].data  = acc_resp_i.data;
        end
    end

    assign resp_hs = acc_resp_valid_i && acc_resp_ready_o && matched;

    // Credit update and unexpected-response detection
    always_comb begin
        unexp_d = acc_resp_valid_i && !matched;
        if (resp_hs && (cnt_q[resp_idx] == '0)) begin
            unexp_d = 1'b1;
        end
        for (int i = 0; i < NrCores; i++) begin
            logic inc, dec;
            inc = accept && (gnt_idx == IdxW'(i));
            dec = resp_hs && (resp_idx == IdxW'(i))
               && (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
        end
    end

    assign unexpected_resp_o = unexp_q;

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            rr_q        <= '0;
            unexp_q     <= 1'b0;
            for (int i = 0; i < NrCores; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            rr_q        <= rr_d;
            unexp_q     <= unexp_d;
            for (int i = 0; i < NrCores; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_snitch_shared_acc_mux.sv
// Directed bench for snitch_shared_acc_mux.
// Four cores, hart base 8, four credits per core.
module tb_snitch_shared_acc_mux;
    import snitch_shared_acc_pkg::*;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst_ni;
    acc_req_t     core_req_i [N];
    logic [N-1:0] core_req_valid_i;
    logic [N-1:0] core_req_ready_o;
    acc_resp_t    core_resp_o [N];
    logic [N-1:0] core_resp_valid_o;
    logic [N-1:0] core_resp_ready_i;
    sh_acc_req_t  acc_req_o;
    logic         acc_req_valid_o;
    logic         acc_req_ready_i;
    sh_acc_resp_t acc_resp_i;
    logic         acc_resp_valid_i;
    logic         acc_resp_ready_o;
    logic         unexpected_resp_o;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    snitch_shared_acc_mux #(
        .NrCores(4),
        .HartIdBase(8),
        .MaxOutstanding(4)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .core_req_i(core_req_i),
        .core_req_valid_i(core_req_valid_i),
        .core_req_ready_o(core_req_ready_o),
        .core_resp_o(core_resp_o),
        .core_resp_valid_o(core_resp_valid_o),
        .core_resp_ready_i(core_resp_ready_i),
        .acc_req_o(acc_req_o),
        .acc_req_valid_o(acc_req_valid_o),
        .acc_req_ready_i(acc_req_ready_i),
        .acc_resp_i(acc_resp_i),
        .acc_resp_valid_i(acc_resp_valid_i),
        .acc_resp_ready_o(acc_resp_ready_o),
        .unexpected_resp_o(unexpected_resp_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [63:0] a,
                           input logic [4:0] id);
        core_req_i[c]           = '0;
        core_req_i[c].data_arga = a;
        core_req_i[c].id        = id;
        core_req_i[c].addr      = 32'(c);
    endtask

    task automatic set_resp(input logic [5:0] h, input logic [63:0] d);
        acc_resp_i       = '{hart_id: h, id: 5'd5, error: 1'b0, data: d};
        acc_resp_valid_i = 1'b1;
    endtask

    task automatic ret_resp(input logic [5:0] h);
        set_resp(h, 64'h0);
        #1;
        chk("ret_valid", 64'(core_resp_valid_o), 64'(1 << (h - 8)));
        tick();
        chk("ret_no_unexp", 64'(unexpected_resp_o), 64'd0);
        acc_resp_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni            = 1'b0;
        core_req_valid_i  = '0;
        core_resp_ready_i = '1;
        acc_req_ready_i   = 1'b1;
        acc_resp_valid_i  = 1'b0;
        acc_resp_i        = '0;
        for (int i = 0; i < N; i++) set_req(i, 64'h100 + 64'(i), 5'(i));
        #2;
        chk("rst_valid", 64'(acc_req_valid_o), 64'd0);
        chk("rst_hart", 64'(acc_req_o.hart_id), 64'd0);
        chk("rst_arga", acc_req_o.data_arga, 64'd0);
        chk("rst_unexp", 64'(unexpected_resp_o), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        tick();

        // Round robin: all valid, grants 0,1,2,3,0 back to back
        core_req_valid_i = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", 64'(core_req_ready_o), 64'(1 << (k % 4)));
            tick();
            chk("rr_valid", 64'(acc_req_valid_o), 64'd1);
            chk("rr_hart", 64'(acc_req_o.hart_id), 64'(8 + k % 4));
            chk("rr_arga", acc_req_o.data_arga, 64'h100 + 64'(k % 4));
        end
        core_req_valid_i = '0;
        tick();
        chk("rr_drained", 64'(acc_req_valid_o), 64'd0);
        ret_resp(6'd8);
        ret_resp(6'd8);
        ret_resp(6'd9);
        ret_resp(6'd10);
        ret_resp(6'd11);

        // Single request from core 2
        set_req(2, 64'h1234, 5'd5);
        core_req_valid_i = 4'b0100;
        #1;
        chk("single_ready", 64'(core_req_ready_o), 64'b0100);
        tick();
        core_req_valid_i = '0;
        chk("single_valid", 64'(acc_req_valid_o), 64'd1);
        chk("single_hart", 64'(acc_req_o.hart_id), 64'd10);
        chk("single_arga", acc_req_o.data_arga, 64'h1234);
        chk("single_id", 64'(acc_req_o.id), 64'd5);
        tick();
        set_resp(6'd10, 64'hBEEF);
        #1;
        chk("single_rvalid", 64'(core_resp_valid_o), 64'b0100);
        chk("single_rdata", core_resp_o[2].data, 64'hBEEF);
        chk("single_rready", 64'(acc_resp_ready_o), 64'd1);
        tick();
        acc_resp_valid_i = 1'b0;
        chk("single_unexp", 64'(unexpected_resp_o), 64'd0);

        // Credit limit on core 1
        core_req_valid_i = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            set_req(1, 64'h200 + 64'(k), 5'(k));
            #1;
            chk("cred_ready", 64'(core_req_ready_o), 64'b0010);
            tick();
        end
        set_req(1, 64'h204, 5'd4);
        #1;
        chk("cred_full", 64'(core_req_ready_o), 64'd0);
        tick();
        chk("cred_drain", 64'(acc_req_valid_o), 64'd0);
        set_resp(6'd9, 64'h0);
        #1;
        chk("cred_same_cyc", 64'(core_req_ready_o), 64'd0);
        chk("cred_rvalid", 64'(core_resp_valid_o), 64'b0010);
        tick();
        acc_resp_valid_i = 1'b0;
        #1;
        chk("cred_freed", 64'(core_req_ready_o), 64'b0010);
        tick();
        core_req_valid_i = '0;
        chk("cred_5th_hart", 64'(acc_req_o.hart_id), 64'd9);
        chk("cred_5th_arga", acc_req_o.data_arga, 64'h204);
        tick();
        for (int k = 0; k < 4; k++) ret_resp(6'd9);

        // Back-pressure
        set_req(3, 64'h333, 5'd3);
        core_req_valid_i = 4'b1000;
        tick();
        acc_req_ready_i = 1'b0;
        set_req(0, 64'h300, 5'd0);
        core_req_valid_i = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", 64'(core_req_ready_o), 64'd0);
            tick();
            chk("bp_valid", 64'(acc_req_valid_o), 64'd1);
            chk("bp_arga", acc_req_o.data_arga, 64'h333);
            chk("bp_hart", 64'(acc_req_o.hart_id), 64'd11);
        end
        acc_req_ready_i = 1'b1;
        #1;
        chk("bp_release", 64'(core_req_ready_o), 64'b0001);
        tick();
        core_req_valid_i = '0;
        chk("bp_load_valid", 64'(acc_req_valid_o), 64'd1);
        chk("bp_load_arga", acc_req_o.data_arga, 64'h300);
        chk("bp_load_hart", 64'(acc_req_o.hart_id), 64'd8);
        tick();
        chk("bp_empty", 64'(acc_req_valid_o), 64'd0);
        ret_resp(6'd11);
        ret_resp(6'd8);

        // Bad responses: unmatched hart, then underflow on core 1
        core_resp_ready_i = '0;
        set_resp(6'd40, 64'h0);
        #1;
        chk("bad_ready", 64'(acc_resp_ready_o), 64'd1);
        chk("bad_rvalid", 64'(core_resp_valid_o), 64'd0);
        tick();
        chk("bad_pulse1", 64'(unexpected_resp_o), 64'd1);
        core_resp_ready_i = '1;
        set_resp(6'd9, 64'h77);
        #1;
        chk("uf_rvalid", 64'(core_resp_valid_o), 64'b0010);
        chk("uf_rdata", core_resp_o[1].data, 64'h77);
        tick();
        acc_resp_valid_i = 1'b0;
        chk("uf_pulse2", 64'(unexpected_resp_o), 64'd1);
        tick();
        chk("uf_pulse_end", 64'(unexpected_resp_o), 64'd0);

        // Async reset with a buffered request and three credits on core 0
        core_req_valid_i = 4'b0001;
        tick();
        tick();
        tick();
        core_req_valid_i = '0;
        acc_req_ready_i  = 1'b0;
        chk("ar_pre_valid", 64'(acc_req_valid_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("ar_valid", 64'(acc_req_valid_o), 64'd0);
        chk("ar_hart", 64'(acc_req_o.hart_id), 64'd0);
        tick();
        rst_ni = 1'b1;
        acc_req_ready_i = 1'b1;
        tick();
        set_resp(6'd8, 64'h0);
        #1;
        chk("ar_rvalid", 64'(core_resp_valid_o), 64'b0001);
        tick();
        acc_resp_valid_i = 1'b0;
        chk("ar_cnt_zero", 64'(unexpected_resp_o), 64'd1);
        core_req_valid_i = '1;
        #1;
        chk("ar_rr_zero", 64'(core_req_ready_o), 64'b0001);
        tick();
        core_req_valid_i = '0;
        chk("ar_first_hart", 64'(acc_req_o.hart_id), 64'd8);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
